// File: rtl/tile_locator_pkg.sv
// Shared geometry constants, field widths and FSM state type for the tile locator.
package tile_geom_pkg;
    localparam int unsigned WIDTH    = 20;
    localparam int unsigned SPACING  = 5;
    localparam int unsigned PITCH    = WIDTH + SPACING;
    localparam int unsigned GRID_DIM = 16;

    localparam int unsigned PIX_W  = 11;
    localparam int unsigned POS_W  = 4;
    localparam int unsigned ADDR_W = 9;
    localparam int unsigned OFF_W  = 5;
    // Shifted coordinate (pixel + SPACING) needs one extra bit.
    localparam int unsigned O_W    = PIX_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        DONE
    } state_t;
endpackage

// File: rtl/tile_locator_if.sv
// Request/response bundle for tile_locator; offset fields exist only with TILE_LOCATOR_OFFSET_EN.
interface tile_locator_if;
    import tile_geom_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [PIX_W-1:0]  pixelX;
    logic [PIX_W-1:0]  pixelY;
    logic              out_valid;
    logic              out_ready;
    logic [POS_W-1:0]  positionX;
    logic [POS_W-1:0]  positionY;
    logic [ADDR_W-1:0] address;
    logic              hit;
    logic              oob;
`ifdef TILE_LOCATOR_OFFSET_EN
    logic [OFF_W-1:0]  offsetX;
    logic [OFF_W-1:0]  offsetY;
`endif

    modport master (
        output in_valid, pixelX, pixelY, out_ready,
        input  in_ready, out_valid, positionX, positionY, address, hit, oob
`ifdef TILE_LOCATOR_OFFSET_EN
        , input offsetX, offsetY
`endif
    );

    modport slave (
        input  in_valid, pixelX, pixelY, out_ready,
        output in_ready, out_valid, positionX, positionY, address, hit, oob
`ifdef TILE_LOCATOR_OFFSET_EN
        , output offsetX, offsetY
`endif
    );
endinterface

// File: rtl/tile_locator_pitch_divider.sv
// Per-axis restoring divider: one subtraction of DIVISOR per step while r >= DIVISOR.
module pitch_divider
    import tile_geom_pkg::*;
#(
    parameter int unsigned DIVISOR = PITCH
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             load,
    input  logic [O_W-1:0]   load_val,
    input  logic             step,
    output logic             done,
    output logic [O_W-1:0]   r,
    output logic [POS_W-1:0] q
);
    localparam logic [O_W-1:0] DIV_O = O_W'(DIVISOR);

    logic [O_W-1:0]   r_q, r_d;
    logic [POS_W-1:0] q_q, q_d;
    logic             ge;

    assign ge   = (r_q >= DIV_O);
    assign done = !ge;
    assign r    = r_q;
    assign q    = q_q;

    always_comb begin
        r_d = r_q;
        q_d = q_q;
        if (load) begin
            r_d = load_val;
            q_d = '0;
        end else if (step && ge) begin
            r_d = r_q - DIV_O;
            q_d = q_q + POS_W'(1);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_q <= '0;
            q_q <= '0;
        end else begin
            r_q <= r_d;
            q_q <= q_d;
        end
    end
endmodule

// File: rtl/tile_locator.sv
// Pixel -> tile grid position / BRAM address with hit and out-of-bounds flags.
// Optional offset outputs are built when TILE_LOCATOR_OFFSET_EN is defined.
module tile_locator #(
    parameter int unsigned WIDTH   = tile_geom_pkg::WIDTH,
    parameter int unsigned SPACING = tile_geom_pkg::SPACING
) (
    input  logic           clock,
    input  logic           resetn,
    tile_locator_if.slave  bus
);
    import tile_geom_pkg::*;

    localparam int unsigned    TILE_PITCH = WIDTH + SPACING;
    localparam logic [O_W-1:0] WIDTH_O    = O_W'(WIDTH);
    localparam logic [O_W-1:0] SPACING_O  = O_W'(SPACING);
    localparam logic [O_W-1:0] LIMIT_O    = O_W'(GRID_DIM * TILE_PITCH);

    state_t            state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [POS_W-1:0]  pos_x_q, pos_x_d;
    logic [POS_W-1:0]  pos_y_q, pos_y_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic              hit_q, hit_d;
    logic              oob_q, oob_d;
`ifdef TILE_LOCATOR_OFFSET_EN
    logic [OFF_W-1:0]  offset_x_q, offset_x_d;
    logic [OFF_W-1:0]  offset_y_q, offset_y_d;
`endif

    logic             load, step, oob_now;
    logic             done_x, done_y;
    logic [O_W-1:0]   o_x, o_y, r_x, r_y;
    logic [POS_W-1:0] q_x, q_y;

    assign bus.in_ready = (state_q == IDLE);
    assign load         = (state_q == IDLE) && bus.in_valid;
    assign o_x          = {1'b0, bus.pixelX} + SPACING_O;
    assign o_y          = {1'b0, bus.pixelY} + SPACING_O;

    // Remainders only shrink, so r >= LIMIT can only be seen on the first DIV edge.
    assign oob_now = (r_x >= LIMIT_O) || (r_y >= LIMIT_O);
    assign step    = (state_q == DIV) && !oob_now;

    pitch_divider #(.DIVISOR(TILE_PITCH)) u_div_x (
        .clock    (clock),
        .resetn   (resetn),
        .load     (load),
        .load_val (o_x),
        .step     (step),
        .done     (done_x),
        .r        (r_x),
        .q        (q_x)
    );

    pitch_divider #(.DIVISOR(TILE_PITCH)) u_div_y (
        .clock    (clock),
        .resetn   (resetn),
        .load     (load),
        .load_val (o_y),
        .step     (step),
        .done     (done_y),
        .r        (r_y),
        .q        (q_y)
    );

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        address_d   = address_q;
        hit_d       = hit_q;
        oob_d       = oob_q;
`ifdef TILE_LOCATOR_OFFSET_EN
        offset_x_d  = offset_x_q;
        offset_y_d  = offset_y_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) state_d = DIV;
            end
            DIV: begin
                if (oob_now) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    pos_x_d     = '0;
                    pos_y_d     = '0;
                    address_d   = '0;
                    hit_d       = 1'b0;
                    oob_d       = 1'b1;
`ifdef TILE_LOCATOR_OFFSET_EN
                    offset_x_d  = '0;
                    offset_y_d  = '0;
`endif
                end else if (done_x && done_y) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    pos_x_d     = q_x;
                    pos_y_d     = q_y;
                    address_d   = {1'b0, q_y, q_x};
                    hit_d       = (r_x < WIDTH_O) && (r_y < WIDTH_O);
                    oob_d       = 1'b0;
`ifdef TILE_LOCATOR_OFFSET_EN
                    offset_x_d  = r_x[OFF_W-1:0];
                    offset_y_d  = r_y[OFF_W-1:0];
`endif
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            pos_x_q     <= '0;
            pos_y_q     <= '0;
            address_q   <= '0;
            hit_q       <= 1'b0;
            oob_q       <= 1'b0;
`ifdef TILE_LOCATOR_OFFSET_EN
            offset_x_q  <= '0;
            offset_y_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            address_q   <= address_d;
            hit_q       <= hit_d;
            oob_q       <= oob_d;
`ifdef TILE_LOCATOR_OFFSET_EN
            offset_x_q  <= offset_x_d;
            offset_y_q  <= offset_y_d;
`endif
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.positionX = pos_x_q;
    assign bus.positionY = pos_y_q;
    assign bus.address   = address_q;
    assign bus.hit       = hit_q;
    assign bus.oob       = oob_q;
`ifdef TILE_LOCATOR_OFFSET_EN
    assign bus.offsetX   = offset_x_q;
    assign bus.offsetY   = offset_y_q;
`endif
endmodule
